// File: rtl/imem_loader_pkg.sv
// Shared state encoding, error codes and address constants for the
// instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  // Reserved base for memory-mapping the loader status registers later on.
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  // A load is in flight: the idle counter runs and the CPU is held.
  function automatic logic is_loading(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Big-endian byte-to-word assembler: the first byte of each group of four
// lands in [31:23+1]; word_valid fires combinationally with the 4th byte.
module byte_to_word (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The 4th byte is appended on the fly so the word is usable in its own cycle.
  assign word_valid = byte_valid && (cnt_q == 2'd3);
  assign word       = {shift_q, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/payload/checksum frame from the UART
// byte stream and writes big-endian words into the instruction RAM.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS) + 1;
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_n;
  logic [IDXW-1:0] idx_q;
  logic [15:0]     len_q;
  logic [15:0]     len_word;
  logic [7:0]      csum_q;
  logic [TW-1:0]   idle_q;
  logic            start_acc;
  logic            tmo;
  logic            last_word;
  logic            byte_valid;
  logic            word_valid;
  logic [31:0]     word;
  logic            err_set;
  logic [1:0]      err_cause;

  assign start_acc  = start && !is_loading(state_q) && (state_q != S_LEN_HI);
  assign tmo        = (idle_q == TMO_LAST);
  assign len_word   = {len_q[15:8], rx_data};
  assign last_word  = (32'(idx_q) + 32'd1) == 32'(len_q);
  assign byte_valid = rx_valid && (state_q == S_DATA);

  byte_to_word u_b2w (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_acc),
    .byte_valid (byte_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // rx_valid is tested before the timeout so a byte in the last idle cycle wins.
  always_comb begin
    state_n   = state_q;
    err_set   = 1'b0;
    err_cause = ERR_NONE;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          state_n = S_LEN_LO;
        end else if (tmo) begin
          state_n = S_ERR; err_set = 1'b1; err_cause = ERR_TMO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          if (len_word > 16'(DEPTH_WORDS)) begin
            state_n = S_ERR; err_set = 1'b1; err_cause = ERR_LEN;
          end else if (len_word == 16'd0) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_DATA;
          end
        end else if (tmo) begin
          state_n = S_ERR; err_set = 1'b1; err_cause = ERR_TMO;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (word_valid && last_word) state_n = S_CSUM;
        end else if (tmo) begin
          state_n = S_ERR; err_set = 1'b1; err_cause = ERR_TMO;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ERR; err_set = 1'b1; err_cause = ERR_CSUM;
          end
        end else if (tmo) begin
          state_n = S_ERR; err_set = 1'b1; err_cause = ERR_TMO;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err_code <= ERR_NONE;
      idx_q    <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      idle_q   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_acc) begin
        err_code <= ERR_NONE;
        idx_q    <= '0;
        len_q    <= '0;
        csum_q   <= '0;
        idle_q   <= '0;
      end else begin
        if (is_loading(state_q) && !rx_valid) idle_q <= idle_q + 1'b1;
        else                                  idle_q <= '0;
        if (state_q == S_LEN_HI && rx_valid) len_q[15:8] <= rx_data;
        if (state_q == S_LEN_LO && rx_valid) len_q[7:0]  <= rx_data;
        if (byte_valid) csum_q <= csum_q ^ rx_data;
        if (word_valid) begin
          wr_en   <= 1'b1;
          wr_data <= word;
          wr_addr <= BASE_ADDR + (32'(idx_q) << 2);
          idx_q   <= idx_q + 1'b1;
        end
        if (err_set) err_code <= err_cause;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a byte-stream reference
// interpreter that predicts the write sequence and final status.
module tb_imem_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned TMO   = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [1:0]  E_NONE = 2'd0, E_LEN = 2'd1, E_TMO = 2'd2, E_CSUM = 2'd3;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en, cpu_hold, busy, done, error;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int width_viol = 0;
  logic prev_en = 1'b0;

  logic [7:0]  fr_bytes[$];
  int          fr_gaps[$];
  logic [63:0] exp_w[$];
  logic [63:0] got_w[$];
  bit          exp_done;
  logic [1:0]  exp_code;

  imem_loader #(
    .DEPTH_WORDS    (DEPTH),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got_w.push_back({wr_addr, wr_data});
      if (prev_en) width_viol++;
    end
    prev_en = wr_en;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back, 1: small random, 2: one gap just under the limit, 3: one gap at the limit
  task automatic set_gaps(input int mode);
    int p;
    fr_gaps.delete();
    foreach (fr_bytes[i]) fr_gaps.push_back(mode == 0 ? 0 : int'($urandom_range(0, 3)));
    if (fr_gaps.size() > 0 && mode >= 2) begin
      p = $urandom_range(0, fr_gaps.size() - 1);
      fr_gaps[p] = (mode == 2) ? TMO - 1 : TMO;
    end
  endtask

  // Interprets the frame as the loader should, byte by byte.
  task automatic model(input int gaps[$]);
    int phase = 0;
    int n = 0;
    int nb = 0;
    int widx = 0;
    logic [7:0] cs = '0;
    logic [31:0] w = '0;
    bit fin = 0;
    exp_w.delete();
    exp_done = 0;
    exp_code = E_TMO;
    for (int i = 0; i < fr_bytes.size() && !fin; i++) begin
      if (gaps[i] >= TMO) begin
        fin = 1;
      end else begin
        case (phase)
          0: begin n = int'(fr_bytes[i]) * 256; phase = 1; end
          1: begin
            n = n + int'(fr_bytes[i]);
            if (n > DEPTH)  begin exp_code = E_LEN; fin = 1; end
            else if (n == 0) phase = 3;
            else             phase = 2;
          end
          2: begin
            cs = cs ^ fr_bytes[i];
            w  = {w[23:0], fr_bytes[i]};
            nb++;
            if (nb % 4 == 0) begin
              exp_w.push_back({BASE + 32'(4 * widx), w});
              widx++;
              if (widx == n) phase = 3;
            end
          end
          default: begin
            if (fr_bytes[i] == cs) begin exp_done = 1; exp_code = E_NONE; end
            else exp_code = E_CSUM;
            fin = 1;
          end
        endcase
      end
    end
  endtask

  task automatic send_frame(input bit busy_start);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < fr_bytes.size(); i++) begin
      if (busy_start && i == 2) begin start = 1'b1; tick(); start = 1'b0; end
      repeat (fr_gaps[i]) tick();
      rx_valid = 1'b1; rx_data = fr_bytes[i]; tick(); rx_valid = 1'b0;
      rx_data = 8'($urandom);
    end
    repeat (TMO + 4) tick();
  endtask

  task automatic run_frame(input bit busy_start);
    int eff[$];
    eff = fr_gaps;
    if (busy_start) eff[2] = eff[2] + 1;
    model(eff);
    got_w.delete();
    send_frame(busy_start);
    check_eq("wr_count", 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check_eq("wr_addr_data", got_w[i], exp_w[i]);
    check_eq("done", done, exp_done);
    check_eq("error", error, !exp_done);
    check_eq("err_code", err_code, exp_code);
    check_eq("cpu_hold", cpu_hold, !exp_done);
    check_eq("busy", busy, 1'b0);
  endtask

  task automatic gen_random(output bit busy_start);
    int n, r, sel;
    logic [7:0] cs, b;
    fr_bytes.delete();
    sel = $urandom_range(0, 11);
    if (sel < 7)       n = $urandom_range(0, 6);
    else if (sel == 7) n = DEPTH;
    else if (sel == 8) n = DEPTH + 1;
    else if (sel == 9) n = 256 + $urandom_range(0, DEPTH);
    else               n = $urandom_range(1, 12);
    fr_bytes.push_back(8'(n >> 8));
    fr_bytes.push_back(8'(n));
    cs = '0;
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        cs = cs ^ b;
        fr_bytes.push_back(b);
      end
      r = $urandom_range(0, 4);
      fr_bytes.push_back(r == 0 ? cs ^ 8'($urandom_range(1, 255)) : cs);
    end else begin
      repeat (3) fr_bytes.push_back(8'($urandom));
    end
    if ($urandom_range(0, 7) == 0) begin
      r = $urandom_range(1, fr_bytes.size());
      repeat (r) void'(fr_bytes.pop_back());
    end
    set_gaps($urandom_range(0, 3));
    busy_start = (fr_bytes.size() > 2) && (n <= DEPTH) && (fr_gaps[0] < TMO) &&
                 (fr_gaps[1] < TMO) && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    bit bs;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_outputs", {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, err_code}, '0);

    fr_bytes = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h40, 8'h63};
    set_gaps(1);
    run_frame(0);
    check_eq("two_word_addr1", got_w.size() > 1 ? got_w[1] : 64'h0, {32'h4, 32'h2008_0040});

    fr_bytes = '{8'h00, 8'h21};
    set_gaps(0);
    run_frame(0);

    fr_bytes = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h40, 8'h62};
    set_gaps(0);
    run_frame(0);

    fr_bytes = '{8'h00, 8'h01, 8'h08};
    set_gaps(0);
    run_frame(0);

    fr_bytes = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h8A};
    set_gaps(1);
    run_frame(1);

    fr_bytes = '{8'h00, 8'h00, 8'h00};
    set_gaps(0);
    run_frame(0);

    for (int k = 0; k < 40; k++) begin
      gen_random(bs);
      run_frame(bs);
    end

    fr_bytes = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    got_w.delete();
    start = 1'b1; tick(); start = 1'b0;
    foreach (fr_bytes[i]) begin
      rx_valid = 1'b1; rx_data = fr_bytes[i]; tick();
    end
    rx_valid = 1'b0; reset = 1'b1;
    tick();
    check_eq("rst_mid_outputs", {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, err_code}, '0);
    check_eq("rst_mid_writes", 64'(got_w.size()), 64'd1);
    check_eq("rst_mid_word", got_w.size() > 0 ? got_w[0] : 64'h0, {BASE, 32'h1122_3344});
    reset = 1'b0;
    tick();

    fr_bytes = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    set_gaps(0);
    run_frame(0);

    check_eq("wr_en_width", 64'(width_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
